fpm_lod_norm_pipe: RTL and testbench

//  Parametrised, pipelined leading-one / leading-zero detector and normaliser for the FP

---
 rtl/fpm_lod_norm_pipe.sv | 85 ++++++++
 tb/tb_fpm_lod_norm_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpm_lod_norm_pipe.sv
// Leading-one/leading-zero detector and left normaliser for mantissa words, two register stages.
// Latency: 2 cycles from input transfer to result, 1 word/cycle while out_ready is high.
// Backpressure: a stalled output holds both stages; in_ready falls only once S1 is also full.
module fpm_lod_norm_pipe #(
    parameter int  WIDTH = 22,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic             s1_mode;

    logic             s1_en;
    logic             s2_en;

    logic [WIDTH-1:0] scan_vec;
    logic [WIDTH-1:0] det_onehot;
    logic [CW-1:0]    det_count;
    logic             det_zero;
    logic [WIDTH-1:0] det_norm;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            s1_data  <= in_data;
            s1_mode  <= in_mode;
        end
    end

    // Ascending scan: the last hit written is the highest set index, giving MSB-first priority.
    always_comb begin
        scan_vec   = s1_mode ? ~s1_data : s1_data;
        det_onehot = '0;
        det_count  = CW'(WIDTH);
        det_zero   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (scan_vec[i]) begin
                det_onehot    = '0;
                det_onehot[i] = 1'b1;
                det_count     = CW'(WIDTH - 1 - i);
                det_zero      = 1'b0;
            end
        end
        // Shift the original word, not the scan vector, so mode 1 keeps the true mantissa bits.
        det_norm = det_zero ? '0 : (s1_data << det_count);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_count  <= '0;
            out_zero   <= 1'b0;
            out_norm   <= '0;
        end else if (s2_en) begin
            out_valid  <= s1_valid;
            out_onehot <= det_onehot;
            out_count  <= det_count;
            out_zero   <= det_zero;
            out_norm   <= det_norm;
        end
    end

endmodule

// File: tb/tb_fpm_lod_norm_pipe.sv
// Directed and randomised bench for fpm_lod_norm_pipe at WIDTH=22.
module tb_fpm_lod_norm_pipe;

    localparam int W  = 22;
    localparam int CW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_onehot;
    logic [CW-1:0] out_count;
    logic          out_zero;
    logic [W-1:0]  out_norm;

    int n_cmp = 0;
    int n_bad = 0;

    fpm_lod_norm_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_onehot(out_onehot), .out_count(out_count), .out_zero(out_zero), .out_norm(out_norm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic          mode;
        logic [W-1:0]  onehot;
        logic [CW-1:0] count;
        logic          zero;
        logic [W-1:0]  norm;
    } vec_t;

    // Hand-computed vectors.
    vec_t vt [7];
    initial begin
        vt[0] = '{22'h200000, 1'b0, 22'h200000, 5'd0,  1'b0, 22'h200000};
        vt[1] = '{22'h000000, 1'b0, 22'h000000, 5'd22, 1'b1, 22'h000000};
        vt[2] = '{22'h00F000, 1'b0, 22'h008000, 5'd6,  1'b0, 22'h3C0000};
        vt[3] = '{22'h3FFFFE, 1'b1, 22'h000001, 5'd21, 1'b0, 22'h000000};
        vt[4] = '{22'h3FFFFF, 1'b1, 22'h000000, 5'd22, 1'b1, 22'h000000};
        vt[5] = '{22'h000001, 1'b0, 22'h000001, 5'd21, 1'b0, 22'h200000};
        vt[6] = '{22'h2AAAAA, 1'b1, 22'h100000, 5'd1,  1'b0, 22'h155554};
    end

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: scan down from the MSB and stop at the first target bit.
    function automatic logic [49:0] ref_model(input logic [W-1:0] d, input logic m);
        logic [W-1:0]  v;
        logic [W-1:0]  oh;
        logic [CW-1:0] cnt;
        logic [W-1:0]  nrm;
        int            k;
        bit            found;
        v = m ? ~d : d;
        k = W - 1;
        found = 0;
        while (k >= 0 && !found) begin
            if (v[k]) found = 1;
            else k--;
        end
        oh  = '0;
        cnt = 5'd22;
        nrm = '0;
        if (found) begin
            oh[k] = 1'b1;
            cnt   = 5'(W - 1 - k);
            nrm   = d << (W - 1 - k);
        end
        return {oh, cnt, !found, nrm};
    endfunction

    function automatic logic [49:0] vec_res(input int i);
        return {vt[i].onehot, vt[i].count, vt[i].zero, vt[i].norm};
    endfunction

    function automatic logic [49:0] dut_res();
        return {out_onehot, out_count, out_zero, out_norm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        in_valid = 1'b1;
        in_data  = vt[i].data;
        in_mode  = vt[i].mode;
        tick();
        in_valid = 1'b0;
        chk_val($sformatf("vec%0d_lat1_valid", i), out_valid, 0);
        tick();
        chk_val($sformatf("vec%0d_valid", i), out_valid, 1);
        chk_val($sformatf("vec%0d_result", i), dut_res(), vec_res(i));
        tick();
    endtask

    logic [49:0] sb[$];
    logic [49:0] exp_r;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
        #2;
        chk_val("rst_out_valid", out_valid, 0);
        chk_val("rst_outputs", dut_res(), 50'd0);
        chk_val("rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(i);

        // Back-to-back stream of 8 words.
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                in_data  = vt[c % 7].data;
                in_mode  = vt[c % 7].mode;
                chk_val($sformatf("stream_in_ready%0d", c), in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 1) begin
                chk_val($sformatf("stream_valid%0d", c - 1), out_valid, 1);
                chk_val($sformatf("stream_res%0d", c - 1), dut_res(), vec_res((c - 1) % 7));
            end
        end
        in_valid = 1'b0;
        tick();
        chk_val("stream_drained", out_valid, 0);

        // Stall: words 2, 5, 6 offered with out_ready low.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = vt[2].data; in_mode = vt[2].mode;
        chk_val("stall_rdy_a", in_ready, 1);
        tick();
        in_data = vt[5].data; in_mode = vt[5].mode;
        chk_val("stall_rdy_b", in_ready, 1);
        tick();
        in_data = vt[6].data; in_mode = vt[6].mode;
        for (int c = 0; c < 5; c++) begin
            chk_val($sformatf("stall_refuse%0d", c), in_ready, 0);
            chk_val($sformatf("stall_valid%0d", c), out_valid, 1);
            chk_val($sformatf("stall_hold%0d", c), dut_res(), vec_res(2));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk_val("stall_release_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk_val("stall_out_b", dut_res(), vec_res(5));
        chk_val("stall_out_b_valid", out_valid, 1);
        tick();
        chk_val("stall_out_c", dut_res(), vec_res(6));
        chk_val("stall_out_c_valid", out_valid, 1);
        tick();
        chk_val("stall_empty", out_valid, 0);

        // Reset with two words in flight.
        in_valid = 1'b1; in_data = vt[0].data; in_mode = vt[0].mode;
        tick();
        in_data = vt[2].data; in_mode = vt[2].mode;
        tick();
        in_valid = 1'b0;
        chk_val("inflight_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk_val("midrst_valid", out_valid, 0);
        chk_val("midrst_outputs", dut_res(), 50'd0);
        tick();
        rst = 1'b0;
        tick();
        chk_val("postrst_stale1", out_valid, 0);
        tick();
        chk_val("postrst_stale2", out_valid, 0);
        run_vec(6);

        // Random traffic against the reference model and an order scoreboard.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom) >> $urandom_range(0, W);
            if ($urandom_range(0, 7) == 0) in_data = '1;
            in_mode   = $urandom_range(0, 1) == 1;
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk_val("rand_unexpected_out", 1, 0);
                end else begin
                    exp_r = sb.pop_front();
                    chk_val("rand_res", dut_res(), exp_r);
                end
            end
            if (in_valid && in_ready) sb.push_back(ref_model(in_data, in_mode));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk_val("drain_unexpected_out", 1, 0);
                end else begin
                    exp_r = sb.pop_front();
                    chk_val("drain_res", dut_res(), exp_r);
                end
            end
            tick();
        end
        chk_val("rand_all_delivered", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
